// File: rtl/task_dispatcher.sv
// task_dispatcher: scans per-task ready words one slot per cycle, dispatches the
// highest-priority ready task with an Execute op, holds it for a time slice (or
// until the task drops its ready word), then issues a Finish op and rescans.
// Optional macro TASK_DISPATCHER_AGING_EN adds per-slot 3-bit starvation
// counters; a slot that has lost seven completed scans wins the next one.
module task_dispatcher #(
    parameter int unsigned N_TASKS      = 4,
    parameter int unsigned TIMESLICE    = 16,
    parameter int unsigned SCAN_RESTART = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [8*N_TASKS-1:0] in_tasks,
    output logic [15:0]          out_op,
    output logic                 op_valid,
    output logic [3:0]           cur_task,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(N_TASKS);
    localparam int unsigned CNT_W = $clog2(TIMESLICE);
    localparam int unsigned RST_W = $clog2(SCAN_RESTART + 1);

    localparam logic [3:0] OP_EXEC = 4'b0111;
    localparam logic [3:0] OP_FIN  = 4'b1111;

    typedef enum logic [2:0] {
        S_SCAN     = 3'd0,
        S_WAIT     = 3'd1,
        S_DISPATCH = 3'd2,
        S_RUN      = 3'd3,
        S_RETIRE   = 3'd4
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   best_idx;
    logic               best_valid;
    logic [IDX_W-1:0]   run_idx;
    logic [CNT_W-1:0]   slice_cnt;
    logic [RST_W-1:0]   wait_cnt;

    logic [7:0]         cur_word;
    logic [7:0]         best_word;
    logic [7:0]         run_word;
    logic               cand;
    logic               take;
    logic               last_scan;
    logic               fin_valid;
    logic [IDX_W-1:0]   fin_idx;
    logic [7:0]         fin_word;

    // Slot words at the scan pointer, the latched best and the running task
    always_comb begin
        cur_word  = 8'h00;
        best_word = 8'h00;
        run_word  = 8'h00;
        for (int unsigned k = 0; k < N_TASKS; k++) begin
            if (scan_idx == IDX_W'(k)) cur_word  = in_tasks[8*k +: 8];
            if (best_idx == IDX_W'(k)) best_word = in_tasks[8*k +: 8];
            if (run_idx  == IDX_W'(k)) run_word  = in_tasks[8*k +: 8];
        end
    end

    assign cand      = (cur_word != 8'h00);
    assign last_scan = (state == S_SCAN) && (scan_idx == IDX_W'(N_TASKS - 1));
    assign fin_valid = best_valid || take;
    assign fin_idx   = take ? scan_idx : best_idx;
    assign fin_word  = take ? cur_word : best_word;

`ifdef TASK_DISPATCHER_AGING_EN
    logic [2:0]         skip_cnt [N_TASKS];
    logic               best_aged;
    logic [N_TASKS-1:0] cand_seen;
    logic [N_TASKS-1:0] seen_all;
    logic               cur_aged;

    // Starvation state of the slot under the scan pointer, and all candidates of this scan
    always_comb begin
        cur_aged = 1'b0;
        seen_all = cand_seen;
        for (int unsigned k = 0; k < N_TASKS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                cur_aged = (skip_cnt[k] == 3'd7);
                if (cand) seen_all[k] = 1'b1;
            end
        end
    end

    // An aged candidate beats any non-aged best; among aged slots the first found wins
    assign take = cand && (!best_valid ||
                           (!best_aged && (cur_aged || (cur_word[3:0] > best_word[3:0]))));

    // Skip counters: losers of a completed scan age, the dispatched winner clears
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            best_aged <= 1'b0;
            cand_seen <= '0;
            for (int unsigned k = 0; k < N_TASKS; k++) skip_cnt[k] <= 3'd0;
        end else if (state == S_SCAN) begin
            if (last_scan) begin
                best_aged <= 1'b0;
                cand_seen <= '0;
                if (fin_valid) begin
                    for (int unsigned k = 0; k < N_TASKS; k++) begin
                        if (fin_idx == IDX_W'(k))
                            skip_cnt[k] <= 3'd0;
                        else if (seen_all[k] && (skip_cnt[k] != 3'd7))
                            skip_cnt[k] <= skip_cnt[k] + 3'd1;
                    end
                end
            end else begin
                cand_seen <= seen_all;
                if (take) best_aged <= cur_aged;
            end
        end
    end
`else
    // Strict priority: only a strictly higher prio replaces the best, so ties keep the lower index
    assign take = cand && (!best_valid || (cur_word[3:0] > best_word[3:0]));
`endif

    // Main controller: scan, dispatch, run the slice, retire
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_SCAN;
            scan_idx   <= '0;
            best_idx   <= '0;
            best_valid <= 1'b0;
            run_idx    <= '0;
            slice_cnt  <= '0;
            wait_cnt   <= '0;
            out_op     <= 16'h0000;
            op_valid   <= 1'b0;
            cur_task   <= 4'h0;
            busy       <= 1'b0;
        end else begin
            op_valid <= 1'b0;
            case (state)
                S_SCAN: begin
                    if (take) begin
                        best_idx   <= scan_idx;
                        best_valid <= 1'b1;
                    end
                    if (last_scan) begin
                        scan_idx   <= '0;
                        best_valid <= 1'b0;
                        if (fin_valid) begin
                            state    <= S_DISPATCH;
                            run_idx  <= fin_idx;
                            cur_task <= fin_word[7:4];
                            out_op   <= {4'h0, fin_word[7:4], OP_EXEC, 4'h0};
                            op_valid <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= RST_W'(SCAN_RESTART - 1);
                        end
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) state <= S_SCAN;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                S_DISPATCH: begin
                    slice_cnt <= CNT_W'(TIMESLICE - 1);
                    state     <= S_RUN;
                end
                S_RUN: begin
                    // Slice expiry and task withdrawal share one exit, so only one Finish
                    if ((slice_cnt == '0) || (run_word == 8'h00)) begin
                        state    <= S_RETIRE;
                        out_op   <= {4'h0, cur_task, OP_FIN, 4'h0};
                        op_valid <= 1'b1;
                    end else begin
                        slice_cnt <= slice_cnt - 1'b1;
                    end
                end
                S_RETIRE: begin
                    cur_task <= 4'h0;
                    busy     <= 1'b0;
                    state    <= S_SCAN;
                end
                default: state <= S_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_task_dispatcher.sv
// tb_task_dispatcher: randomized and directed checks of task_dispatcher against
// an event-level model (winner by priority/aging rules, op timing by arithmetic).
module tb_task_dispatcher;

    localparam int N = 4;
    localparam int T = 16;
    localparam int R = 2;

    logic           CLK;
    logic           RST;
    logic [8*N-1:0] in_tasks;
    logic [15:0]    out_op;
    logic           op_valid;
    logic [3:0]     cur_task;
    logic           busy;

    logic [7:0] slots [N];
    int         ages  [N];
    int         exp_ids [16];
    int         checks;
    int         failures;

    task_dispatcher #(
        .N_TASKS      (N),
        .TIMESLICE    (T),
        .SCAN_RESTART (R)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_tasks (in_tasks),
        .out_op   (out_op),
        .op_valid (op_valid),
        .cur_task (cur_task),
        .busy     (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always_comb begin
        for (int k = 0; k < N; k++) in_tasks[8*k +: 8] = slots[k];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Model: aged ready slot (lowest index) first, else highest prio with lowest index
    function automatic int pick();
        int best;
        best = -1;
`ifdef TASK_DISPATCHER_AGING_EN
        for (int k = 0; k < N; k++)
            if (slots[k] != 8'h00 && ages[k] >= 7) return k;
`endif
        for (int k = 0; k < N; k++)
            if (slots[k] != 8'h00 && (best < 0 || slots[k][3:0] > slots[best][3:0])) best = k;
        return best;
    endfunction

    function automatic void age_after(input int w);
        for (int k = 0; k < N; k++) begin
            if (k == w) ages[k] = 0;
            else if (slots[k] != 8'h00 && ages[k] < 7) ages[k] = ages[k] + 1;
        end
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        for (int k = 0; k < N; k++) ages[k] = 0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (op_valid !== 1'b0 || busy !== 1'b0 || cur_task !== 4'h0 || out_op !== 16'h0000) begin
            failures++;
            $display("FAIL reset: op_valid=%b busy=%b cur_task=%h out_op=%h, required all zero",
                     op_valid, busy, cur_task, out_op);
        end
    endtask

    // One dispatch from reset; abort_j in 1..T zeroes the winner word before RUN edge j
    task automatic run_dispatch(input string name, input int abort_j);
        int w, e, f, id;
        logic [15:0] exp_op, ex_op, fi_op;
        logic exp_v, exp_b;
        logic [3:0] exp_id;
        do_reset();
        w = pick();
        if (w < 0) begin
            for (int k = 1; k <= 3*N + R; k++) begin
                @(negedge CLK);
                checks++;
                if (op_valid !== 1'b0 || busy !== 1'b0 || cur_task !== 4'h0) begin
                    failures++;
                    $display("FAIL %s empty k=%0d: op_valid=%b busy=%b cur_task=%h, required 0 0 0",
                             name, k, op_valid, busy, cur_task);
                end
            end
            return;
        end
        id = int'(slots[w][7:4]);
        e  = N;
        f  = e + 1 + ((abort_j < T) ? abort_j : T);
        ex_op = {4'h0, 4'(id), 4'h7, 4'h0};
        fi_op = {4'h0, 4'(id), 4'hF, 4'h0};
        for (int k = 1; k <= f + 1; k++) begin
            @(negedge CLK);
            exp_v  = (k == e) || (k == f);
            exp_b  = (k >= e) && (k <= f);
            exp_id = exp_b ? 4'(id) : 4'h0;
            exp_op = (k < e) ? 16'h0000 : (k < f) ? ex_op : fi_op;
            checks++;
            if (op_valid !== exp_v || busy !== exp_b || cur_task !== exp_id || out_op !== exp_op) begin
                failures++;
                $display("FAIL %s k=%0d: got v=%b busy=%b cur=%h op=%h, required v=%b busy=%b cur=%h op=%h",
                         name, k, op_valid, busy, cur_task, out_op, exp_v, exp_b, exp_id, exp_op);
            end
            if (abort_j >= 1 && abort_j <= T && k == e + abort_j) slots[w] = 8'h00;
        end
    endtask

    task automatic set_slots(input logic [31:0] packed_words);
        for (int k = 0; k < N; k++) slots[k] = packed_words[8*k +: 8];
    endtask

    task automatic test_single();
        set_slots(32'h00_43_00_00);
        run_dispatch("single", T + 5);
    endtask

    task automatic test_priority_tie();
        set_slots(32'h41_35_25_12);
        run_dispatch("prio_tie", T + 5);
    endtask

    task automatic test_abort();
        set_slots(32'h00_43_00_00);
        run_dispatch("abort3", 3);
        set_slots(32'h00_43_00_00);
        run_dispatch("abort1", 1);
        set_slots(32'h00_43_00_00);
        run_dispatch("abort_at_expiry", T);
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < N; k++)
                slots[k] = ($urandom_range(0, 2) == 0) ? 8'h00 :
                           {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
            run_dispatch("random", int'($urandom_range(1, T + 6)));
        end
    endtask

    task automatic test_empty();
        int waited;
        set_slots(32'h0);
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            checks++;
            if (op_valid !== 1'b0 || busy !== 1'b0 || cur_task !== 4'h0) begin
                failures++;
                $display("FAIL empty k=%0d: op_valid=%b busy=%b cur_task=%h, required 0 0 0",
                         k, op_valid, busy, cur_task);
            end
        end
        slots[1] = 8'h9A;
        waited = 0;
        while (op_valid !== 1'b1 && waited < 2*N + R + 2) begin
            @(negedge CLK);
            waited++;
        end
        checks++;
        if (op_valid !== 1'b1 || out_op !== 16'h0970 || cur_task !== 4'h9) begin
            failures++;
            $display("FAIL empty_wake: v=%b op=%h cur=%h after %0d cycles, required v=1 op=0970 cur=9 within %0d",
                     op_valid, out_op, cur_task, waited, 2*N + R + 2);
        end
    endtask

    task automatic test_reset_mid_run();
        set_slots(32'h00_00_57_00);
        do_reset();
        for (int k = 1; k <= N + 5; k++) @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++;
        if (op_valid !== 1'b0 || busy !== 1'b0 || cur_task !== 4'h0 || out_op !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_run async: v=%b busy=%b cur=%h op=%h, required all zero",
                     op_valid, busy, cur_task, out_op);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 1; k <= N; k++) begin
            @(negedge CLK);
            checks++;
            if (op_valid !== (k == N) || busy !== (k == N)) begin
                failures++;
                $display("FAIL reset_mid_run rescan k=%0d: v=%b busy=%b, required v=%b busy=%b",
                         k, op_valid, busy, k == N, k == N);
            end
        end
        checks++;
        if (out_op !== 16'h0570 || cur_task !== 4'h5) begin
            failures++;
            $display("FAIL reset_mid_run exec: op=%h cur=%h, required op=0570 cur=5", out_op, cur_task);
        end
    endtask

    // Continuous dispatch stream against exp_ids[]; slots held constant
    task automatic stream_check(input string name, input int n_disp);
        int e, f, d;
        logic exp_v, exp_b;
        logic [3:0] exp_id;
        logic [15:0] exp_op;
        d = 0;
        e = N;
        f = e + 1 + T;
        for (int k = 1; d < n_disp; k++) begin
            @(negedge CLK);
            exp_v  = (k == e) || (k == f);
            exp_b  = (k >= e) && (k <= f);
            exp_id = exp_b ? 4'(exp_ids[d]) : 4'h0;
            checks++;
            if (op_valid !== exp_v || busy !== exp_b || cur_task !== exp_id) begin
                failures++;
                $display("FAIL %s k=%0d disp=%0d: v=%b busy=%b cur=%h, required v=%b busy=%b cur=%h",
                         name, k, d, op_valid, busy, cur_task, exp_v, exp_b, exp_id);
            end
            if (exp_v) begin
                exp_op = {4'h0, 4'(exp_ids[d]), (k == e) ? 4'h7 : 4'hF, 4'h0};
                checks++;
                if (out_op !== exp_op) begin
                    failures++;
                    $display("FAIL %s op k=%0d disp=%0d: out_op=%h, required %h",
                             name, k, d, out_op, exp_op);
                end
            end
            if (k == f) begin
                d++;
                e = f + 1 + N;
                f = e + 1 + T;
            end
        end
    endtask

    task automatic test_back_to_back();
        int w;
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < N; k++)
                slots[k] = (k > 0 && $urandom_range(0, 1) == 0) ? 8'h00 :
                           {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
            do_reset();
            for (int d = 0; d < 4; d++) begin
                w = pick();
                exp_ids[d] = int'(slots[w][7:4]);
                age_after(w);
            end
            stream_check("back_to_back", 4);
        end
    endtask

    task automatic test_aging();
        set_slots(32'h00_00_21_1F);
        do_reset();
        for (int d = 0; d < 9; d++) begin
`ifdef TASK_DISPATCHER_AGING_EN
            exp_ids[d] = (d == 7) ? 2 : 1;
`else
            exp_ids[d] = 1;
`endif
        end
        stream_check("aging", 9);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        for (int k = 0; k < N; k++) slots[k] = 8'h00;
        test_reset();
        test_single();
        test_priority_tie();
        test_abort();
        test_empty();
        test_reset_mid_run();
        test_back_to_back();
        test_aging();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
